// File: rtl/cc_cipher.sv
// ChaCha20 XOR data path: latches key/nonce/counter, requests keystream blocks
// from cc_block and XORs a 32-bit word stream with it under valid/ready flow.
module cc_cipher (
   input  logic         i_clk,
   input  logic         i_rstn,
   input  logic         i_start,
   input  logic [255:0] i_key,
   input  logic [95:0]  i_non,
   input  logic [31:0]  i_cnt,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [31:0]  i_data,
   input  logic         i_last,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [31:0]  o_data,
   output logic         o_last,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_cnt_ovf,
   output logic         o_kg_start,
   output logic [255:0] o_kg_key,
   output logic [95:0]  o_kg_non,
   output logic [31:0]  o_kg_cnt,
   input  logic         i_kg_done,
   input  logic [511:0] i_kg_stream
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_CAP   = 3'd3;
   localparam logic [2:0] S_XOR   = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   logic [2:0]   r_state;
   logic [255:0] r_key;
   logic [95:0]  r_non;
   logic [31:0]  r_cnt;
   logic [511:0] r_ks;
   logic [3:0]   r_idx;
   logic         r_ovf;
   logic         r_valid;
   logic [31:0]  r_data;
   logic         r_last;
   logic         r_done;

   logic         w_ready;
   logic         w_acc;
   logic         w_out_hs;
   logic [8:0]   w_ks_msb;
   logic [31:0]  w_ks_word;

   // Keystream word 0 sits in the top 32 bits of the block.
   assign w_ks_msb  = 9'd511 - {r_idx, 5'd0};
   assign w_ks_word = r_ks[w_ks_msb -: 32];

   // The output register frees up in the same cycle it is handed off.
   assign w_ready  = (r_state == S_XOR) && (!r_valid || i_ready);
   assign w_acc    = w_ready && i_valid;
   assign w_out_hs = r_valid && i_ready;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_key   <= '0;
         r_non   <= '0;
         r_cnt   <= '0;
         r_ks    <= '0;
         r_idx   <= '0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;

         if (w_acc) begin
            r_data  <= i_data ^ w_ks_word;
            r_last  <= i_last;
            r_valid <= 1'b1;
         end else if (w_out_hs) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_key   <= i_key;
                  r_non   <= i_non;
                  r_cnt   <= i_cnt;
                  r_ovf   <= 1'b0;
                  r_idx   <= '0;
                  r_state <= S_REQ;
               end
            end
            S_REQ:  r_state <= S_WAIT;
            S_WAIT: if (i_kg_done) r_state <= S_CAP;
            S_CAP: begin
               r_ks    <= i_kg_stream;
               r_state <= S_XOR;
            end
            S_XOR: begin
               if (w_acc) begin
                  if (i_last) begin
                     r_state <= S_DRAIN;
                  end else if (r_idx == 4'd15) begin
                     r_idx   <= '0;
                     r_cnt   <= r_cnt + 32'd1;
                     if (&r_cnt) r_ovf <= 1'b1;
                     r_state <= S_REQ;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end
            end
            S_DRAIN: begin
               if (w_out_hs) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ready    = w_ready;
   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_last     = r_last;
   assign o_busy     = (r_state != S_IDLE);
   assign o_done     = r_done;
   assign o_cnt_ovf  = r_ovf;
   assign o_kg_start = (r_state == S_REQ);
   assign o_kg_key   = r_key;
   assign o_kg_non   = r_non;
   assign o_kg_cnt   = r_cnt;

endmodule

// File: tb/tb_cc_cipher.sv
// Self-checking bench for cc_cipher: a behavioural ChaCha20 keystream source
// stands in for cc_block, and a scoreboard queue checks every output word.
module tb_cc_cipher;

   logic         i_clk = 1'b0;
   logic         i_rstn = 1'b0;
   logic         i_start = 1'b0;
   logic [255:0] i_key = '0;
   logic [95:0]  i_non = '0;
   logic [31:0]  i_cnt = '0;
   logic         i_valid = 1'b0;
   logic [31:0]  i_data = '0;
   logic         i_last = 1'b0;
   logic         i_ready = 1'b1;
   logic         i_kg_done;
   logic [511:0] i_kg_stream;
   logic         o_ready, o_valid, o_last, o_busy, o_done, o_cnt_ovf, o_kg_start;
   logic [31:0]  o_data, o_kg_cnt;
   logic [255:0] o_kg_key;
   logic [95:0]  o_kg_non;

   cc_cipher dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_key(i_key),
      .i_non(i_non), .i_cnt(i_cnt), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_last(i_last), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done),
      .o_cnt_ovf(o_cnt_ovf), .o_kg_start(o_kg_start), .o_kg_key(o_kg_key),
      .o_kg_non(o_kg_non), .o_kg_cnt(o_kg_cnt), .i_kg_done(i_kg_done),
      .i_kg_stream(i_kg_stream)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- ChaCha20 reference ----------------
   function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
      return (v << r) | (v >> (32 - r));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a0, b0, c0, d0);
      logic [31:0] a, b, c, d;
      a = a0; b = b0; c = c0; d = d0;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] chacha(input logic [255:0] k, input logic [95:0] n,
                                           input logic [31:0] c);
      logic [31:0]  s [16];
      logic [31:0]  x [16];
      logic [511:0] r;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
      s[12] = c;
      for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
      x = s;
      for (int i = 0; i < 10; i++) begin
         {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
         {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
         {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
         {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
         {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
         {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
         {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
         {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
      end
      for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
      return r;
   endfunction

   // ---------------- keystream generator model ----------------
   logic [31:0]  kg_log [$];
   int unsigned  kg_cd;
   logic [511:0] kg_pend;

   always @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         kg_cd       <= 0;
         i_kg_done   <= 1'b0;
         i_kg_stream <= '0;
      end else begin
         i_kg_done <= 1'b0;
         if (kg_cd == 1) begin
            i_kg_done   <= 1'b1;
            i_kg_stream <= kg_pend;
         end
         if (kg_cd != 0) kg_cd <= kg_cd - 1;
         if (o_kg_start) begin
            kg_cd       <= 3 + $urandom_range(0, 2);
            kg_pend     <= chacha(o_kg_key, o_kg_non, o_kg_cnt);
            i_kg_stream <= '0;
            kg_log.push_back(o_kg_cnt);
         end
      end
   end

   // ---------------- downstream ready ----------------
   bit hold_rdy = 1'b0;
   bit rdy_rand = 1'b0;
   always @(posedge i_clk) begin
      #1;
      if (!hold_rdy) i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // ---------------- scoreboard / monitor ----------------
   logic [31:0] exp_q [$];
   logic        exp_last_q [$];
   logic [31:0] got [64];
   int          out_cnt = 0;
   int          done_cnt = 0;
   bit          want_done = 1'b0;

   always @(negedge i_clk) begin : mon
      logic [31:0] e;
      logic        l;
      if (i_rstn) begin
         if (want_done) begin
            check("done_pulse", o_done, 1'b1);
            want_done = 1'b0;
         end else if (o_done) begin
            check("spurious_done", o_done, 1'b0);
         end
         if (o_done) done_cnt++;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", o_valid, 1'b0);
            end else begin
               e = exp_q.pop_front();
               l = exp_last_q.pop_front();
               check("out_data", o_data, e);
               check("out_last", o_last, l);
               if (out_cnt < 64) got[out_cnt] = o_data;
               out_cnt++;
               if (l) want_done = 1'b1;
            end
         end
      end
   end

   // ---------------- driver ----------------
   logic [255:0] cfg_k;
   logic [95:0]  cfg_n;
   logic [31:0]  cfg_c;
   logic [31:0]  pt [64];
   int           acc_cnt = 0;
   int           acc_time [64];

   task automatic send_word(input int w, input logic last);
      logic [511:0] ks;
      int t;
      ks = chacha(cfg_k, cfg_n, cfg_c + 32'(w / 16));
      i_valid = 1'b1;
      i_data  = pt[w];
      i_last  = last;
      t = 0;
      @(negedge i_clk);
      while (!o_ready && t < 300) begin
         @(negedge i_clk);
         t++;
      end
      if (!o_ready) begin
         check("accept_timeout", o_ready, 1'b1);
      end else begin
         exp_q.push_back(pt[w] ^ ks[511-32*(w%16) -: 32]);
         exp_last_q.push_back(last);
         acc_time[w] = cyc;
         acc_cnt++;
         if (w == 16) check("w16_after_req2", kg_log.size(), 2);
      end
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
   endtask

   task automatic pulse_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
      @(posedge i_clk); #1;
      i_key = k; i_non = n; i_cnt = c; i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
   endtask

   task automatic run_msg(input logic [255:0] k, input logic [95:0] n,
                          input logic [31:0] c, input int nw);
      int d0, t;
      cfg_k = k; cfg_n = n; cfg_c = c;
      kg_log.delete();
      out_cnt = 0;
      d0 = done_cnt;
      pulse_start(k, n, c);
      for (int w = 0; w < nw; w++) send_word(w, w == nw - 1);
      t = 0;
      while (done_cnt == d0 && t < 500) begin
         @(negedge i_clk);
         t++;
      end
      @(negedge i_clk);
      check("msg_done", done_cnt - d0, 1);
      check("msg_words", out_cnt, nw);
      check("idle_after", o_busy, 1'b0);
   endtask

   logic [422:0] w_outs;
   assign w_outs = {o_ready, o_valid, o_data, o_last, o_busy, o_done, o_cnt_ovf,
                    o_kg_start, o_kg_key, o_kg_non, o_kg_cnt};

   logic [255:0] rfc_k;
   logic [95:0]  rfc_n;
   logic [31:0]  ct [64];
   logic [31:0]  orig [64];

   initial begin : main
      string msg;
      int    nw;
      logic [31:0] wd;
      logic [255:0] k2;
      logic [95:0]  n2;
      for (int i = 0; i < 32; i++) rfc_k[8*i +: 8] = 8'(i);
      rfc_n = {32'h0, 32'h4a000000, 32'h0};

      repeat (3) @(negedge i_clk);
      check("reset_outs", w_outs, '0);
      i_rstn = 1'b1;

      // RFC 8439 single word
      pt[0] = 32'h6964614c;
      run_msg(rfc_k, rfc_n, 32'd1, 1);
      check("rfc_word", got[0], 32'h9a352e6e);
      check("rfc_kg_starts", kg_log.size(), 1);

      // Full RFC message, zero-padded last word
      msg = "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
      nw = (msg.len() + 3) / 4;
      for (int w = 0; w < nw; w++) begin
         wd = '0;
         for (int j = 0; j < 4; j++)
            if (4*w + j < msg.len()) wd[8*j +: 8] = msg[4*w + j];
         pt[w] = wd;
      end
      run_msg(rfc_k, rfc_n, 32'd1, nw);
      check("full_first", got[0], 32'h9a352e6e);
      check("full_kg_starts", kg_log.size(), 2);
      if (kg_log.size() == 2) begin
         check("full_kg_cnt0", kg_log[0], 32'd1);
         check("full_kg_cnt1", kg_log[1], 32'd2);
      end
      for (int w = 0; w < nw; w++) begin
         orig[w] = pt[w];
         ct[w]   = got[w];
      end

      // Round trip under random back-pressure
      rdy_rand = 1'b1;
      for (int w = 0; w < nw; w++) pt[w] = ct[w];
      run_msg(rfc_k, rfc_n, 32'd1, nw);
      for (int w = 0; w < nw; w++) check("roundtrip", got[w], orig[w]);

      // Held back-pressure then full-rate resume
      rdy_rand = 1'b0;
      hold_rdy = 1'b1;
      i_ready  = 1'b0;
      for (int w = 0; w < 8; w++) pt[w] = $urandom();
      fork
         run_msg(rfc_k, rfc_n, 32'd5, 8);
         begin : bp
            int t, a0;
            logic [31:0] d0;
            t = 0;
            while (!o_valid && t < 100) begin
               @(negedge i_clk);
               t++;
            end
            check("bp_valid", o_valid, 1'b1);
            d0 = o_data;
            a0 = acc_cnt;
            repeat (5) begin
               @(negedge i_clk);
               check("bp_stable", o_data, d0);
               check("bp_ready", o_ready, 1'b0);
               check("bp_noacc", acc_cnt, a0);
            end
            @(posedge i_clk); #1;
            hold_rdy = 1'b0;
            i_ready  = 1'b1;
         end
      join
      check("bp_full_rate", acc_time[7] - acc_time[1], 6);

      // Counter wrap
      for (int w = 0; w < 20; w++) pt[w] = $urandom();
      run_msg(rfc_k, rfc_n, 32'hFFFFFFFF, 20);
      check("wrap_kg_starts", kg_log.size(), 2);
      if (kg_log.size() == 2) begin
         check("wrap_cnt0", kg_log[0], 32'hFFFFFFFF);
         check("wrap_cnt1", kg_log[1], 32'h0);
      end
      repeat (3) @(negedge i_clk);
      check("ovf_sticky", o_cnt_ovf, 1'b1);

      // i_start while busy is ignored; ovf cleared by the accepted start
      rdy_rand = 1'b1;
      for (int i = 0; i < 8; i++) k2[32*i +: 32] = $urandom();
      n2 = {$urandom(), $urandom(), $urandom()};
      for (int w = 0; w < 20; w++) pt[w] = $urandom();
      fork
         run_msg(k2, n2, 32'd7, 20);
         begin : bs
            int t;
            t = 0;
            while (kg_log.size() < 1 && t < 100) begin
               @(negedge i_clk);
               t++;
            end
            check("ovf_cleared", o_cnt_ovf, 1'b0);
            @(posedge i_clk); #1;
            i_key = ~k2; i_non = ~n2; i_cnt = 32'd99; i_start = 1'b1;
            @(posedge i_clk); #1;
            i_start = 1'b0;
            @(negedge i_clk);
            check("busy_key", o_kg_key, k2);
            check("busy_non", o_kg_non, n2);
            check("busy_cnt", o_kg_cnt, 32'd7);
         end
      join
      check("busy_kg_starts", kg_log.size(), 2);
      if (kg_log.size() == 2) check("busy_kg_cnt1", kg_log[1], 32'd8);

      // Reset while waiting for keystream
      rdy_rand = 1'b0;
      kg_log.delete();
      pulse_start(rfc_k, rfc_n, 32'd1);
      begin : rw
         int t;
         t = 0;
         while (kg_log.size() < 1 && t < 100) begin
            @(negedge i_clk);
            t++;
         end
      end
      @(negedge i_clk);
      check("wait_busy", o_busy, 1'b1);
      i_rstn = 1'b0;
      #1;
      check("rst_wait_outs", w_outs, '0);
      @(negedge i_clk);
      check("rst_wait_outs2", w_outs, '0);
      exp_q.delete();
      exp_last_q.delete();
      want_done = 1'b0;
      @(negedge i_clk);
      i_rstn = 1'b1;

      pt[0] = 32'h6964614c;
      run_msg(rfc_k, rfc_n, 32'd1, 1);
      check("post_rst_word", got[0], 32'h9a352e6e);

      repeat (2) @(negedge i_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
